// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset sequencer: state codes,
// opcodes, datapath select codes and the packed control word.
package mc_pkg;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;
  localparam logic [3:0] S_JAL    = 4'd12;
  localparam logic [3:0] S_TRAP   = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUB_RT      = 2'b00;
  localparam logic [1:0] ALUB_FOUR    = 2'b01;
  localparam logic [1:0] ALUB_IMM     = 2'b10;
  localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  // ready_gated: pcwrite/irwrite only fire once memory completes.
  // done/done_on_ready: last cycle of an instruction, unconditionally or on mem_ready.
  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       pc_to_reg;
    logic [1:0] regdst;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       halted;
    logic       done;
    logic       done_on_ready;
    logic       ready_gated;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_IDLE = '0;

endpackage

// File: rtl/mc_ctrl_rom.sv
// Moore output decode: maps the current state to the datapath control word.
// Handshake and reset qualification happen in the top module.
module mc_ctrl_rom
  import mc_pkg::*;
(
  input  logic [3:0] state,
  output ctrl_word_t cw
);

  always_comb begin
    // NOTE: every field starts at zero so unlisted outputs stay 0 and no latch is inferred.
    cw = CTRL_IDLE;
    case (state)
      S_FETCH: begin
        cw.memread     = 1'b1;
        cw.alusrcb     = ALUB_FOUR;
        cw.aluop       = ALUOP_ADD;
        cw.pcsource    = PCSRC_ALU;
        cw.irwrite     = 1'b1;
        cw.pcwrite     = 1'b1;
        cw.ready_gated = 1'b1;
      end
      S_DECODE: begin
        cw.alusrcb = ALUB_IMM_SH2;
      end
      S_MEMADR, S_ADDIEX: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = ALUB_IMM;
      end
      S_MEMRD: begin
        cw.memread = 1'b1;
        cw.iord    = 1'b1;
      end
      S_MEMWR: begin
        cw.memwrite      = 1'b1;
        cw.iord          = 1'b1;
        cw.done_on_ready = 1'b1;
      end
      S_MEMWB: begin
        cw.memtoreg = 1'b1;
        cw.regwrite = 1'b1;
        cw.done     = 1'b1;
      end
      S_EXEC: begin
        cw.alusrca = 1'b1;
        cw.alusrcb = ALUB_RT;
        cw.aluop   = ALUOP_FUNCT;
      end
      S_RWB: begin
        cw.regdst   = REGDST_RD;
        cw.regwrite = 1'b1;
        cw.done     = 1'b1;
      end
      S_ADDIWB: begin
        cw.regdst   = REGDST_RT;
        cw.regwrite = 1'b1;
        cw.done     = 1'b1;
      end
      S_BRANCH: begin
        cw.alusrca     = 1'b1;
        cw.alusrcb     = ALUB_RT;
        cw.aluop       = ALUOP_SUB;
        cw.pcwritecond = 1'b1;
        cw.pcsource    = PCSRC_ALUOUT;
        cw.done        = 1'b1;
      end
      S_JUMP: begin
        cw.pcwrite  = 1'b1;
        cw.pcsource = PCSRC_JUMP;
        cw.done     = 1'b1;
      end
      S_JAL: begin
        cw.pcwrite   = 1'b1;
        cw.pcsource  = PCSRC_JUMP;
        cw.regdst    = REGDST_RA;
        cw.pc_to_reg = 1'b1;
        cw.regwrite  = 1'b1;
        cw.done      = 1'b1;
      end
      S_TRAP: begin
        cw.halted = 1'b1;
      end
      default: cw = CTRL_IDLE;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle sequencer: state register, opcode dispatch, memory-ready stalls,
// reset gating of write strobes and the retired-instruction counter.
module mc_control_unit
  import mc_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opcode,
  input  logic                mem_ready,
  output logic                pcwrite,
  output logic                pcwritecond,
  output logic                iord,
  output logic                memread,
  output logic                memwrite,
  output logic                irwrite,
  output logic                memtoreg,
  output logic                pc_to_reg,
  output logic [1:0]          regdst,
  output logic                regwrite,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic [1:0]          aluop,
  output logic [1:0]          pcsource,
  output logic                instr_done,
  output logic                halted,
  output logic [3:0]          state,
  output logic [RETIRE_W-1:0] retired
);

  ctrl_word_t cw;
  logic [3:0] next_state;
  logic       ready_ok;

  mc_ctrl_rom u_rom (
    .state (state),
    .cw    (cw)
  );

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:     next_state = S_EXEC;
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          OP_JAL:       next_state = S_JAL;
          OP_ADDI:      next_state = S_ADDIEX;
          default:      next_state = S_TRAP;
        endcase
      end
      // IR is stable here, so only lw/sw can arrive; anything else is treated as illegal.
      S_MEMADR: begin
        if (opcode == OP_LW)      next_state = S_MEMRD;
        else if (opcode == OP_SW) next_state = S_MEMWR;
        else                      next_state = S_TRAP;
      end
      S_MEMRD:  next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC:   next_state = S_RWB;
      S_ADDIEX: next_state = S_ADDIWB;
      S_MEMWB, S_RWB, S_ADDIWB,
      S_BRANCH, S_JUMP, S_JAL: next_state = S_FETCH;
      S_TRAP:   next_state = S_TRAP;
      default:  next_state = S_FETCH;
    endcase
  end

  // Reset suppresses architectural writes combinationally, even before the first edge.
  assign ready_ok    = ~cw.ready_gated | mem_ready;
  assign pcwrite     = cw.pcwrite & ready_ok & ~reset;
  assign irwrite     = cw.irwrite & ready_ok & ~reset;
  assign pcwritecond = cw.pcwritecond & ~reset;
  assign regwrite    = cw.regwrite & ~reset;
  assign memwrite    = cw.memwrite & ~reset;

  assign iord      = cw.iord;
  assign memread   = cw.memread;
  assign memtoreg  = cw.memtoreg;
  assign pc_to_reg = cw.pc_to_reg;
  assign regdst    = cw.regdst;
  assign alusrca   = cw.alusrca;
  assign alusrcb   = cw.alusrcb;
  assign aluop     = cw.aluop;
  assign pcsource  = cw.pcsource;
  assign halted    = cw.halted;

  assign instr_done = cw.done | (cw.done_on_ready & mem_ready);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state   <= S_FETCH;
      retired <= '0;
    end else begin
      state <= next_state;
      if (instr_done) retired <= retired + RETIRE_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: walks each instruction class, stalls,
// the trap state and reset in the middle of a memory wait.
module tb_mc_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
  logic        memtoreg, pc_to_reg, regwrite, alusrca, instr_done, halted;
  logic [1:0]  regdst, alusrcb, aluop, pcsource;
  logic [3:0]  state;
  logic [31:0] retired;

  int errors = 0;
  int checks = 0;

  mc_control_unit #(.RETIRE_W(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .pcwrite     (pcwrite),
    .pcwritecond (pcwritecond),
    .iord        (iord),
    .memread     (memread),
    .memwrite    (memwrite),
    .irwrite     (irwrite),
    .memtoreg    (memtoreg),
    .pc_to_reg   (pc_to_reg),
    .regdst      (regdst),
    .regwrite    (regwrite),
    .alusrca     (alusrca),
    .alusrcb     (alusrcb),
    .aluop       (aluop),
    .pcsource    (pcsource),
    .instr_done  (instr_done),
    .halted      (halted),
    .state       (state),
    .retired     (retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance one edge and land 1ns after it; inputs change after that point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [4:0] strobes;

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b1;
    opcode    = 6'h00;
    settle();
    check("rst_pcwrite_pre", {31'd0, pcwrite}, 32'd0);
    check("rst_irwrite_pre", {31'd0, irwrite}, 32'd0);

    tick();
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_retired", retired, 32'd0);
    check("rst_irwrite_forced", {31'd0, irwrite}, 32'd0);
    check("rst_memread", {31'd0, memread}, 32'd1);
    reset = 1'b0;
    settle();
    check("fetch_irwrite", {31'd0, irwrite}, 32'd1);
    check("fetch_pcwrite", {31'd0, pcwrite}, 32'd1);
    check("fetch_alusrcb", {30'd0, alusrcb}, 32'd1);

    // lw, zero wait states
    opcode = 6'h23;
    tick();
    check("lw_decode", {28'd0, state}, 32'd1);
    check("lw_decode_alusrcb", {30'd0, alusrcb}, 32'd3);
    tick();
    check("lw_memadr", {28'd0, state}, 32'd2);
    check("lw_memadr_srca", {31'd0, alusrca}, 32'd1);
    check("lw_memadr_srcb", {30'd0, alusrcb}, 32'd2);
    tick();
    opcode = 6'h3F;
    settle();
    check("lw_memrd", {28'd0, state}, 32'd3);
    check("lw_memrd_iord", {31'd0, iord}, 32'd1);
    check("lw_memrd_memread", {31'd0, memread}, 32'd1);
    check("lw_memrd_done", {31'd0, instr_done}, 32'd0);
    tick();
    check("lw_memwb", {28'd0, state}, 32'd4);
    check("lw_memwb_memtoreg", {31'd0, memtoreg}, 32'd1);
    check("lw_memwb_regwrite", {31'd0, regwrite}, 32'd1);
    check("lw_memwb_done", {31'd0, instr_done}, 32'd1);
    check("lw_memwb_retired", retired, 32'd0);
    tick();
    check("lw_back_fetch", {28'd0, state}, 32'd0);
    check("lw_retired", retired, 32'd1);

    // FETCH stall for 3 cycles, then beq
    mem_ready = 1'b0;
    opcode    = 6'h04;
    settle();
    for (int i = 0; i < 3; i++) begin
      check("stall_state", {28'd0, state}, 32'd0);
      check("stall_memread", {31'd0, memread}, 32'd1);
      check("stall_irwrite", {31'd0, irwrite}, 32'd0);
      check("stall_pcwrite", {31'd0, pcwrite}, 32'd0);
      if (i < 2) tick();
    end
    mem_ready = 1'b1;
    settle();
    check("stall_end_irwrite", {31'd0, irwrite}, 32'd1);
    check("stall_end_pcwrite", {31'd0, pcwrite}, 32'd1);
    tick();
    check("beq_decode", {28'd0, state}, 32'd1);
    tick();
    check("beq_branch", {28'd0, state}, 32'd8);
    check("beq_pcwritecond", {31'd0, pcwritecond}, 32'd1);
    check("beq_aluop", {30'd0, aluop}, 32'd1);
    check("beq_pcsource", {30'd0, pcsource}, 32'd1);
    check("beq_alusrca", {31'd0, alusrca}, 32'd1);
    check("beq_done", {31'd0, instr_done}, 32'd1);
    check("beq_pcwrite", {31'd0, pcwrite}, 32'd0);
    tick();
    check("beq_back_fetch", {28'd0, state}, 32'd0);
    check("beq_retired", retired, 32'd2);

    // jal
    opcode = 6'h03;
    tick();
    tick();
    check("jal_state", {28'd0, state}, 32'd12);
    check("jal_regdst", {30'd0, regdst}, 32'd2);
    check("jal_pc_to_reg", {31'd0, pc_to_reg}, 32'd1);
    check("jal_regwrite", {31'd0, regwrite}, 32'd1);
    check("jal_pcwrite", {31'd0, pcwrite}, 32'd1);
    check("jal_pcsource", {30'd0, pcsource}, 32'd2);
    tick();
    check("jal_back_fetch", {28'd0, state}, 32'd0);
    check("jal_retired", retired, 32'd3);

    // R-type
    opcode = 6'h00;
    tick();
    tick();
    check("r_exec", {28'd0, state}, 32'd6);
    check("r_exec_aluop", {30'd0, aluop}, 32'd2);
    check("r_exec_regwrite", {31'd0, regwrite}, 32'd0);
    tick();
    check("r_rwb", {28'd0, state}, 32'd7);
    check("r_rwb_regdst", {30'd0, regdst}, 32'd1);
    check("r_rwb_regwrite", {31'd0, regwrite}, 32'd1);
    tick();
    check("r_retired", retired, 32'd4);

    // addi
    opcode = 6'h08;
    tick();
    tick();
    check("addi_ex", {28'd0, state}, 32'd10);
    check("addi_ex_srcb", {30'd0, alusrcb}, 32'd2);
    tick();
    check("addi_wb", {28'd0, state}, 32'd11);
    check("addi_wb_regdst", {30'd0, regdst}, 32'd0);
    check("addi_wb_regwrite", {31'd0, regwrite}, 32'd1);
    tick();
    check("addi_retired", retired, 32'd5);

    // j
    opcode = 6'h02;
    tick();
    tick();
    check("j_state", {28'd0, state}, 32'd9);
    check("j_pcwrite", {31'd0, pcwrite}, 32'd1);
    check("j_pc_to_reg", {31'd0, pc_to_reg}, 32'd0);
    tick();
    check("j_retired", retired, 32'd6);

    // sw, zero wait: 4 cycles
    opcode = 6'h2B;
    tick();
    tick();
    tick();
    check("sw_memwr", {28'd0, state}, 32'd5);
    check("sw_memwrite", {31'd0, memwrite}, 32'd1);
    check("sw_iord", {31'd0, iord}, 32'd1);
    check("sw_done", {31'd0, instr_done}, 32'd1);
    tick();
    check("sw_back_fetch", {28'd0, state}, 32'd0);
    check("sw_retired", retired, 32'd7);

    // sw stalled in MEMWR, reset during the wait
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    check("swr_memwr", {28'd0, state}, 32'd5);
    check("swr_memwrite", {31'd0, memwrite}, 32'd1);
    check("swr_done_wait", {31'd0, instr_done}, 32'd0);
    tick();
    check("swr_hold", {28'd0, state}, 32'd5);
    reset = 1'b1;
    settle();
    check("swr_memwrite_forced", {31'd0, memwrite}, 32'd0);
    check("swr_retired_pre", retired, 32'd7);
    tick();
    reset     = 1'b0;
    mem_ready = 1'b1;
    settle();
    check("swr_state_fetch", {28'd0, state}, 32'd0);
    check("swr_retired_zero", retired, 32'd0);

    // beq to make retired nonzero, then illegal opcode -> TRAP
    opcode = 6'h04;
    tick();
    tick();
    tick();
    check("pre_trap_retired", retired, 32'd1);
    opcode = 6'h3F;
    tick();
    tick();
    check("trap_state", {28'd0, state}, 32'd13);
    check("trap_halted", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      mem_ready = i[0];
      settle();
      strobes = {pcwrite, pcwritecond, irwrite, regwrite, memwrite};
      check("trap_strobes", {27'd0, strobes}, 32'd0);
      check("trap_hold", {28'd0, state}, 32'd13);
      tick();
    end
    check("trap_retired", retired, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    check("trap_rst_state", {28'd0, state}, 32'd0);
    check("trap_rst_halted", {31'd0, halted}, 32'd0);
    check("trap_rst_retired", retired, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_control_unit.md
Name: mc_control_unit

Overview:
Multi-cycle sequencer for the MIPS-subset datapath. The datapath shares one memory port between instruction fetch and data access, and has an instruction register (IR) plus ALUOut/MDR holding registers. This block is a Moore FSM that steps each instruction through fetch/decode/execute/memory/writeback and drives every datapath mux select and write strobe. It also stalls on a memory-ready handshake, traps illegal opcodes, and counts retired instructions.

Parameters:
RETIRE_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  system clock; all state changes on posedge.
reset  in  1  synchronous, active-high reset.
opcode  in  6  IR[31:26] (IR output, stable after FETCH).
mem_ready  in  1  memory handshake; 1 = access completes this cycle.
pcwrite  out  1  unconditional PC load.
pcwritecond  out  1  PC load qualified by ALU zero (gated in datapath).
iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
memread  out  1  memory read request.
memwrite  out  1  memory write request.
irwrite  out  1  IR load.
memtoreg  out  1  register write-data select: 0 = ALUOut, 1 = MDR.
pc_to_reg  out  1  register write-data override = PC (jal).
regdst  out  2  write register select: 00 = rt, 01 = rd, 10 = r31.
regwrite  out  1  register file write enable.
alusrca  out  1  ALU A select: 0 = PC, 1 = rs.
alusrcb  out  2  ALU B select: 00 = rt, 01 = 4, 10 = sext imm, 11 = sext imm<<2.
aluop  out  2  to ALU control: 00 = add, 01 = sub, 10 = funct.
pcsource  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
instr_done  out  1  one-cycle pulse on the final cycle of each instruction.
halted  out  1  1 while in TRAP.
state  out  4  current state (debug/verification).
retired  out  RETIRE_W  retired-instruction count.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11, JAL=12, TRAP=13. Encodings 14–15 go to FETCH on the next edge.
- Transitions:
  - FETCH → DECODE when mem_ready=1, else hold.
  - DECODE dispatch by opcode:
    - 0x00 → EXEC
    - 0x23 (lw) or 0x2B (sw) → MEMADR
    - 0x04 → BRANCH
    - 0x02 → JUMP
    - 0x03 → JAL
    - 0x08 → ADDIEX
    - any other opcode → TRAP
  - MEMADR → MEMRD if lw, → MEMWR if sw.
  - MEMRD → MEMWB when mem_ready=1, else hold.
  - MEMWR → FETCH when mem_ready=1, else hold.
  - EXEC → RWB; ADDIEX → ADDIWB.
  - MEMWB, RWB, ADDIWB, BRANCH, JUMP, JAL → FETCH.
  - TRAP holds until reset.
- Outputs are Moore decodes of state; every output not listed for a state is 0.
  - FETCH: memread=1, alusrcb=01. irwrite=pcwrite=mem_ready; these are the only mem_ready-dependent outputs.
  - DECODE: alusrcb=11.
  - MEMADR, ADDIEX: alusrca=1, alusrcb=10.
  - MEMRD: memread=1, iord=1, held for the whole wait.
  - MEMWR: memwrite=1, iord=1, held for the whole wait.
  - MEMWB: memtoreg=1, regwrite=1.
  - EXEC: alusrca=1, aluop=10.
  - RWB: regdst=01, regwrite=1.
  - ADDIWB: regwrite=1.
  - BRANCH: alusrca=1, aluop=01, pcwritecond=1, pcsource=01.
  - JUMP: pcwrite=1, pcsource=10.
  - JAL: pcwrite=1, pcsource=10, regdst=10, pc_to_reg=1, regwrite=1. The register file captures the pre-edge PC (already PC+4).
  - TRAP: halted=1.
- instr_done=1 in the exit cycle of MEMWB, RWB, ADDIWB, BRANCH, JUMP, JAL, and of MEMWR when mem_ready=1.
- retired increments by 1 on each instr_done and wraps modulo 2^RETIRE_W.
- Instruction latencies with zero wait states: lw 5, sw 4, R/addi 4, beq/j/jal 3 cycles. Each wait cycle adds 1.
- Reset:
  - While reset=1: pcwrite, pcwritecond, irwrite, regwrite and memwrite are forced to 0 combinationally, regardless of state.
  - At the edge with reset=1: state ← FETCH, retired ← 0. This applies in any state, including mid-wait and TRAP.
  - After reset releases, outputs are the FETCH decode.
- opcode is sampled only in DECODE and MEMADR; other values are ignored.

Decomposition:
- Package mc_pkg: state encodings, opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_ADDI), and aluop/alusrcb/pcsource/regdst codes.
- One combinational sub-module, mc_ctrl_rom: state → control word.
- The top module holds the state register, next-state logic, mem_ready gating, reset gating and the retired counter.

Test Plan:
1. Reset, then lw (0x23) with mem_ready=1 → states 0,1,2,3,4. MEMWB has memtoreg=1, regwrite=1. instr_done pulses in cycle 5; retired=1.
2. FETCH with mem_ready=0 for 3 cycles → memread=1, irwrite=0, pcwrite=0 for those 3 cycles. On the 4th cycle irwrite=pcwrite=1, then DECODE.
3. beq (0x04) → states 0,1,8. BRANCH has pcwritecond=1, aluop=01, pcsource=01, alusrca=1. 3-cycle instruction, retired+1.
4. jal (0x03) → state 12 with regdst=10, pc_to_reg=1, regwrite=1, pcwrite=1, pcsource=10, then FETCH.
5. opcode 0x3F → TRAP, halted=1. No write strobe for 10 cycles, retired unchanged. After reset: state=0, halted=0.
6. sw with mem_ready=0, reset asserted in MEMWR → memwrite=0 in the reset cycle. Next state FETCH, retired=0.
